pipe_controller: RTL and testbench

// - 5-stage (IF/ID/EX/MEM/WB) successor of the single-cycle LEGv8 controller: decodes opcode in ID, carries control bits down ID/EX, EX/MEM, MEM/WB registers.
// - Adds load-use stall, EX forwarding select, CBZ/CBNZ/B resolution in MEM with flush, illegal-opcode flag, stall counter. Datapath regs/muxes external.

---
 rtl/pipe_ctrl_pkg.sv | 107 ++++++++++
 rtl/pipe_ctrl_if.sv | 44 ++++
 rtl/pipe_controller_hazard_unit.sv | 57 +++++
 rtl/pipe_controller.sv | 127 ++++++++++++
 tb/tb_pipe_controller.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, control-word types and the ID-stage opcode decoder
// for the 5-stage LEGv8 pipeline controller.
package pipe_ctrl_pkg;

  localparam int unsigned OP_W   = 11;
  localparam int unsigned RA_W   = 5;
  localparam int unsigned ALUC_W = 4;

  localparam logic [RA_W-1:0] XZR = '1;

  localparam logic [OP_W-1:0] OpAdd  = 11'b10001011000;
  localparam logic [OP_W-1:0] OpSub  = 11'b11001011000;
  localparam logic [OP_W-1:0] OpAnd  = 11'b10001010000;
  localparam logic [OP_W-1:0] OpOrr  = 11'b10101010000;
  localparam logic [OP_W-1:0] OpLdur = 11'b11111000010;
  localparam logic [OP_W-1:0] OpStur = 11'b11111000000;
  localparam logic [7:0]      OpCbzHi  = 8'b10110100;
  localparam logic [7:0]      OpCbnzHi = 8'b10110101;
  localparam logic [5:0]      OpBHi    = 6'b000101;

  localparam logic [ALUC_W-1:0] AluAnd   = 4'b0000;
  localparam logic [ALUC_W-1:0] AluOrr   = 4'b0001;
  localparam logic [ALUC_W-1:0] AluAdd   = 4'b0010;
  localparam logic [ALUC_W-1:0] AluSub   = 4'b0110;
  localparam logic [ALUC_W-1:0] AluPassB = 4'b0111;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              nzero;
    logic              uncond;
    logic              alu_src;
    logic [ALUC_W-1:0] alu_control;
    logic              illegal;
  } ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic nzero;
    logic uncond;
  } mem_ctrl_t;

  typedef struct packed {
    ctrl_t           ctrl;
    logic [RA_W-1:0] rn;
    logic [RA_W-1:0] r2;
    logic [RA_W-1:0] rd;
  } idex_t;

  typedef struct packed {
    mem_ctrl_t       ctrl;
    logic [RA_W-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic            reg_write;
    logic            mem_to_reg;
    logic [RA_W-1:0] rd;
  } memwb_t;

  function automatic ctrl_t decode(input logic [OP_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OpAdd: begin c.reg_write = 1'b1; c.alu_control = AluAdd; end
      OpSub: begin c.reg_write = 1'b1; c.alu_control = AluSub; end
      OpAnd: begin c.reg_write = 1'b1; c.alu_control = AluAnd; end
      OpOrr: begin c.reg_write = 1'b1; c.alu_control = AluOrr; end
      OpLdur: begin
        c.alu_src     = 1'b1;
        c.mem_read    = 1'b1;
        c.mem_to_reg  = 1'b1;
        c.reg_write   = 1'b1;
        c.alu_control = AluAdd;
      end
      OpStur: begin
        c.alu_src     = 1'b1;
        c.mem_write   = 1'b1;
        c.alu_control = AluAdd;
      end
      default: begin
        // Branch opcodes carry immediate bits in their low opcode field.
        if (op[OP_W-1 -: 8] == OpCbzHi) begin
          c.branch      = 1'b1;
          c.alu_control = AluPassB;
        end else if (op[OP_W-1 -: 8] == OpCbnzHi) begin
          c.branch      = 1'b1;
          c.nzero       = 1'b1;
          c.alu_control = AluPassB;
        end else if (op[OP_W-1 -: 6] == OpBHi) begin
          c.uncond = 1'b1;
        end else begin
          c.illegal = 1'b1;
        end
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Controller <-> datapath bundle: ID-stage fields in, per-stage controls,
// hazard/forwarding selects and status out.
interface pipe_ctrl_if import pipe_ctrl_pkg::*; #(
  parameter int unsigned CNT_W = 16
) ();

  logic [OP_W-1:0]   instr_id;
  logic [RA_W-1:0]   rn_id;
  logic [RA_W-1:0]   rm_id;
  logic [RA_W-1:0]   rd_id;
  logic              zero_mem;

  logic              reg2loc_id;
  logic              alu_src_ex;
  logic [ALUC_W-1:0] alu_control_ex;
  logic              mem_read_mem;
  logic              mem_write_mem;
  logic              reg_write_wb;
  logic              mem_to_reg_wb;
  logic [RA_W-1:0]   rd_wb;
  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              pc_src_mem;
  logic              illegal_op;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    input  instr_id, rn_id, rm_id, rd_id, zero_mem,
    output reg2loc_id, alu_src_ex, alu_control_ex, mem_read_mem, mem_write_mem,
           reg_write_wb, mem_to_reg_wb, rd_wb, forward_a, forward_b, pc_write,
           ifid_write, ifid_flush, pc_src_mem, illegal_op, stall_count
  );

  modport slave (
    output instr_id, rn_id, rm_id, rd_id, zero_mem,
    input  reg2loc_id, alu_src_ex, alu_control_ex, mem_read_mem, mem_write_mem,
           reg_write_wb, mem_to_reg_wb, rd_wb, forward_a, forward_b, pc_write,
           ifid_write, ifid_flush, pc_src_mem, illegal_op, stall_count
  );

endinterface

// File: rtl/pipe_controller_hazard_unit.sv
// Combinational load-use stall, branch resolution/flush and EX operand
// forwarding selects.
module pipe_hazard_unit import pipe_ctrl_pkg::*; #(
  parameter bit HAZ_EN = 1'b1,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            i_mem_read_ex,
  input  logic [RA_W-1:0] i_rd_ex,
  input  logic [RA_W-1:0] i_rn_ex,
  input  logic [RA_W-1:0] i_r2_ex,
  input  logic [RA_W-1:0] i_rn_id,
  input  logic [RA_W-1:0] i_r2_id,
  input  logic            i_reg_write_mem,
  input  logic            i_branch_mem,
  input  logic            i_nzero_mem,
  input  logic            i_uncond_mem,
  input  logic [RA_W-1:0] i_rd_mem,
  input  logic            i_zero_mem,
  input  logic            i_reg_write_wb,
  input  logic [RA_W-1:0] i_rd_wb,
  output logic            o_stall,
  output logic            o_pc_src,
  output logic            o_pc_write,
  output logic            o_ifid_write,
  output logic            o_ifid_flush,
  output logic [1:0]      o_forward_a,
  output logic [1:0]      o_forward_b
);

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                         input logic rw_mem, input logic [RA_W-1:0] rd_mem,
                                         input logic rw_wb, input logic [RA_W-1:0] rd_wb);
    if (rw_mem && rd_mem != XZR && rd_mem == src) return 2'b10;
    if (rw_wb && rd_wb != XZR && rd_wb == src) return 2'b01;
    return 2'b00;
  endfunction

  logic w_load_use;

  always_comb begin
    w_load_use = i_mem_read_ex && (i_rd_ex != XZR) &&
                 ((i_rd_ex == i_rn_id) || (i_rd_ex == i_r2_id));
    o_stall    = HAZ_EN && w_load_use;
    o_pc_src   = (i_branch_mem && (i_zero_mem ^ i_nzero_mem)) || i_uncond_mem;
    // A taken branch kills the stalled instruction anyway, so fetch proceeds.
    o_pc_write   = !o_stall || o_pc_src;
    o_ifid_write = !o_stall || o_pc_src;
    o_ifid_flush = o_pc_src;
    o_forward_a  = 2'b00;
    o_forward_b  = 2'b00;
    if (FWD_EN) begin
      o_forward_a = fwd_sel(i_rn_ex, i_reg_write_mem, i_rd_mem, i_reg_write_wb, i_rd_wb);
      o_forward_b = fwd_sel(i_r2_ex, i_reg_write_mem, i_rd_mem, i_reg_write_wb, i_rd_wb);
    end
  end

endmodule

// File: rtl/pipe_controller.sv
// 5-stage LEGv8 controller: ID decode, ID/EX, EX/MEM, MEM/WB control
// registers, sticky illegal-opcode flag and saturating stall counter.
module pipe_controller import pipe_ctrl_pkg::*; #(
  parameter bit          HAZ_EN = 1'b1,
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  pipe_ctrl_if.master bus
);

  ctrl_t            w_ctrl_id;
  logic             w_reg2loc_id;
  logic [RA_W-1:0]  w_r2_id;
  idex_t            r_idex, w_idex_nxt;
  exmem_t           r_exmem, w_exmem_nxt;
  memwb_t           r_memwb, w_memwb_nxt;
  logic             r_illegal;
  logic             w_illegal_ex;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall;
  logic             w_flush;
  logic             w_pc_write;
  logic             w_ifid_write;
  logic             w_ifid_flush;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  always_comb begin
    w_ctrl_id    = decode(bus.instr_id);
    w_reg2loc_id = w_ctrl_id.mem_write | w_ctrl_id.branch;
    w_r2_id      = w_reg2loc_id ? bus.rd_id : bus.rm_id;
  end

  pipe_hazard_unit #(
    .HAZ_EN (HAZ_EN),
    .FWD_EN (FWD_EN)
  ) u_hazard (
    .i_mem_read_ex   (r_idex.ctrl.mem_read),
    .i_rd_ex         (r_idex.rd),
    .i_rn_ex         (r_idex.rn),
    .i_r2_ex         (r_idex.r2),
    .i_rn_id         (bus.rn_id),
    .i_r2_id         (w_r2_id),
    .i_reg_write_mem (r_exmem.ctrl.reg_write),
    .i_branch_mem    (r_exmem.ctrl.branch),
    .i_nzero_mem     (r_exmem.ctrl.nzero),
    .i_uncond_mem    (r_exmem.ctrl.uncond),
    .i_rd_mem        (r_exmem.rd),
    .i_zero_mem      (bus.zero_mem),
    .i_reg_write_wb  (r_memwb.reg_write),
    .i_rd_wb         (r_memwb.rd),
    .o_stall         (w_stall),
    .o_pc_src        (w_flush),
    .o_pc_write      (w_pc_write),
    .o_ifid_write    (w_ifid_write),
    .o_ifid_flush    (w_ifid_flush),
    .o_forward_a     (w_fwd_a),
    .o_forward_b     (w_fwd_b)
  );

  // Bubbles are the all-zero reset NOP, register fields included.
  always_comb begin
    w_idex_nxt = '0;
    if (!w_stall && !w_flush) begin
      w_idex_nxt.ctrl = w_ctrl_id;
      w_idex_nxt.rn   = bus.rn_id;
      w_idex_nxt.r2   = w_r2_id;
      w_idex_nxt.rd   = bus.rd_id;
    end
    w_exmem_nxt = '0;
    if (!w_flush) begin
      w_exmem_nxt.ctrl.reg_write  = r_idex.ctrl.reg_write;
      w_exmem_nxt.ctrl.mem_to_reg = r_idex.ctrl.mem_to_reg;
      w_exmem_nxt.ctrl.mem_read   = r_idex.ctrl.mem_read;
      w_exmem_nxt.ctrl.mem_write  = r_idex.ctrl.mem_write;
      w_exmem_nxt.ctrl.branch     = r_idex.ctrl.branch;
      w_exmem_nxt.ctrl.nzero      = r_idex.ctrl.nzero;
      w_exmem_nxt.ctrl.uncond     = r_idex.ctrl.uncond;
      w_exmem_nxt.rd              = r_idex.rd;
    end
    w_memwb_nxt.reg_write  = r_exmem.ctrl.reg_write;
    w_memwb_nxt.mem_to_reg = r_exmem.ctrl.mem_to_reg;
    w_memwb_nxt.rd         = r_exmem.rd;
    // An illegal opcode being flushed out of EX never counts.
    w_illegal_ex = r_idex.ctrl.illegal && !w_flush;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idex      <= '0;
      r_exmem     <= '0;
      r_memwb     <= '0;
      r_illegal   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_idex  <= w_idex_nxt;
      r_exmem <= w_exmem_nxt;
      r_memwb <= w_memwb_nxt;
      if (w_illegal_ex) begin
        r_illegal <= 1'b1;
      end
      if (w_stall && !w_flush && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.reg2loc_id     = w_reg2loc_id;
  assign bus.alu_src_ex     = r_idex.ctrl.alu_src;
  assign bus.alu_control_ex = r_idex.ctrl.alu_control;
  assign bus.mem_read_mem   = r_exmem.ctrl.mem_read;
  assign bus.mem_write_mem  = r_exmem.ctrl.mem_write;
  assign bus.reg_write_wb   = r_memwb.reg_write;
  assign bus.mem_to_reg_wb  = r_memwb.mem_to_reg;
  assign bus.rd_wb          = r_memwb.rd;
  assign bus.forward_a      = w_fwd_a;
  assign bus.forward_b      = w_fwd_b;
  assign bus.pc_write       = w_pc_write;
  assign bus.ifid_write     = w_ifid_write;
  assign bus.ifid_flush     = w_ifid_flush;
  assign bus.pc_src_mem     = w_flush;
  assign bus.illegal_op     = r_illegal | w_illegal_ex;
  assign bus.stall_count    = r_stall_cnt;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: a per-cycle vector table for decode,
// forwarding and load-use, then hand sequences for branches, illegal and reset.
module tb_pipe_controller;

  localparam logic [10:0] O_ADD  = 11'b10001011000;
  localparam logic [10:0] O_SUB  = 11'b11001011000;
  localparam logic [10:0] O_AND  = 11'b10001010000;
  localparam logic [10:0] O_ORR  = 11'b10101010000;
  localparam logic [10:0] O_LDUR = 11'b11111000010;
  localparam logic [10:0] O_STUR = 11'b11111000000;
  localparam logic [10:0] O_CBZ  = 11'b10110100000;
  localparam logic [10:0] O_CBNZ = 11'b10110101000;
  localparam logic [10:0] O_B    = 11'b00010100000;
  localparam logic [10:0] O_BAD  = 11'b11111111111;

  // One row per cycle: ID inputs, then expected outputs before the next edge.
  // fa/fb: 2 = EX/MEM (10), 1 = WB (01), 0 = regfile.
  typedef struct {
    logic [10:0] op;
    int rn, rm, rd;
    int r2l, asrc, aluc, mr, mw, rw, m2r, rdwb, fa, fb, pcw, cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[14];

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(16)) bus ();

  pipe_controller #(
    .HAZ_EN (1'b1),
    .FWD_EN (1'b1),
    .CNT_W  (16)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic drive(input logic [10:0] op, input int rn, input int rm, input int rd);
    bus.instr_id = op;
    bus.rn_id    = 5'(rn);
    bus.rm_id    = 5'(rm);
    bus.rd_id    = 5'(rd);
  endtask

  task automatic nop();
    drive(O_ADD, 31, 31, 31);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{O_ADD,   2,  3,  1,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0};
    vecs[1]  = '{O_SUB,   1,  5,  4,  0, 0, 2, 0, 0, 0, 0,  0, 0, 0, 1, 0};
    vecs[2]  = '{O_ADD,   1,  1,  6,  0, 0, 6, 0, 0, 0, 0,  0, 2, 0, 1, 0};
    vecs[3]  = '{O_LDUR,  2,  0,  9,  0, 0, 2, 0, 0, 1, 0,  1, 1, 1, 1, 0};
    vecs[4]  = '{O_ADD,   9,  3, 10,  0, 1, 2, 0, 0, 1, 0,  4, 0, 0, 0, 0};
    vecs[5]  = '{O_ADD,   9,  3, 10,  0, 0, 0, 1, 0, 1, 0,  6, 0, 0, 1, 1};
    vecs[6]  = '{O_STUR, 10,  0, 11,  1, 0, 2, 0, 0, 1, 1,  9, 1, 0, 1, 1};
    vecs[7]  = '{O_LDUR,  4,  0, 31,  0, 1, 2, 0, 0, 0, 0,  0, 2, 0, 1, 1};
    vecs[8]  = '{O_ADD,  31, 31, 12,  0, 1, 2, 0, 1, 1, 0, 10, 0, 0, 1, 1};
    vecs[9]  = '{O_AND,  12, 12, 13,  0, 0, 2, 1, 0, 0, 0, 11, 0, 0, 1, 1};
    vecs[10] = '{O_ORR,  12, 13, 14,  0, 0, 0, 0, 0, 1, 1, 31, 2, 2, 1, 1};
    vecs[11] = '{O_ADD,  31, 31, 31,  0, 0, 1, 0, 0, 1, 0, 12, 1, 2, 1, 1};
    vecs[12] = '{O_ADD,  31, 31, 31,  0, 0, 2, 0, 0, 1, 0, 13, 0, 0, 1, 1};
    vecs[13] = '{O_ADD,  31, 31, 31,  0, 0, 2, 0, 0, 1, 0, 14, 0, 0, 1, 1};

    rst_n        = 1'b0;
    bus.zero_mem = 1'b0;
    nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (i > 0) step();
      drive(vecs[i].op, vecs[i].rn, vecs[i].rm, vecs[i].rd);
      #3;
      chk($sformatf("r%0d reg2loc", i), int'(bus.reg2loc_id), vecs[i].r2l);
      chk($sformatf("r%0d alu_src_ex", i), int'(bus.alu_src_ex), vecs[i].asrc);
      chk($sformatf("r%0d alu_control_ex", i), int'(bus.alu_control_ex), vecs[i].aluc);
      chk($sformatf("r%0d mem_read_mem", i), int'(bus.mem_read_mem), vecs[i].mr);
      chk($sformatf("r%0d mem_write_mem", i), int'(bus.mem_write_mem), vecs[i].mw);
      chk($sformatf("r%0d reg_write_wb", i), int'(bus.reg_write_wb), vecs[i].rw);
      chk($sformatf("r%0d mem_to_reg_wb", i), int'(bus.mem_to_reg_wb), vecs[i].m2r);
      chk($sformatf("r%0d rd_wb", i), int'(bus.rd_wb), vecs[i].rdwb);
      chk($sformatf("r%0d forward_a", i), int'(bus.forward_a), vecs[i].fa);
      chk($sformatf("r%0d forward_b", i), int'(bus.forward_b), vecs[i].fb);
      chk($sformatf("r%0d pc_write", i), int'(bus.pc_write), vecs[i].pcw);
      chk($sformatf("r%0d ifid_write", i), int'(bus.ifid_write), vecs[i].pcw);
      chk($sformatf("r%0d stall_count", i), int'(bus.stall_count), vecs[i].cnt);
    end

    // CBZ taken: younger ADD X20 (EX) and ADD X21 (ID) must be squashed.
    step(); drive(O_CBZ, 31, 31, 0); #3;
    chk("cbz reg2loc", int'(bus.reg2loc_id), 1);
    step(); drive(O_ADD, 31, 31, 20); #3;
    chk("cbz alu pass_b", int'(bus.alu_control_ex), 7);
    step(); drive(O_ADD, 31, 31, 21); bus.zero_mem = 1'b1; #3;
    chk("cbz pc_src", int'(bus.pc_src_mem), 1);
    chk("cbz ifid_flush", int'(bus.ifid_flush), 1);
    chk("cbz pc_write", int'(bus.pc_write), 1);
    step(); nop(); bus.zero_mem = 1'b0; #3;
    chk("post-flush pc_src", int'(bus.pc_src_mem), 0);
    chk("post-flush ex bubble", int'(bus.alu_control_ex), 0);
    step(); #3;
    chk("flushed exmem reg_write", int'(bus.reg_write_wb), 0);
    step(); #3;
    chk("flushed idex reg_write", int'(bus.reg_write_wb), 0);
    step(); #3;
    chk("post-flush nop reg_write", int'(bus.reg_write_wb), 1);

    // CBNZ with zero set is not taken; zero clear would take it.
    step(); drive(O_CBNZ, 31, 31, 0);
    step(); nop();
    step(); bus.zero_mem = 1'b1; #3;
    chk("cbnz z=1 pc_src", int'(bus.pc_src_mem), 0);
    chk("cbnz z=1 ifid_flush", int'(bus.ifid_flush), 0);
    bus.zero_mem = 1'b0; #1;
    chk("cbnz z=0 pc_src", int'(bus.pc_src_mem), 1);
    bus.zero_mem = 1'b1;
    step(); bus.zero_mem = 1'b0;
    step(); step();

    // Illegal opcode behind a B is flushed from EX and never flagged.
    step(); drive(O_B, 0, 0, 0);
    step(); drive(O_BAD, 0, 0, 0); #3;
    chk("b: illegal before", int'(bus.illegal_op), 0);
    step(); nop(); #3;
    chk("b pc_src", int'(bus.pc_src_mem), 1);
    chk("b: flushed illegal", int'(bus.illegal_op), 0);
    step(); #3;
    chk("b: illegal after", int'(bus.illegal_op), 0);
    step(); #3;
    chk("b: illegal later", int'(bus.illegal_op), 0);

    step(); drive(O_BAD, 0, 0, 0); #3;
    chk("illegal in id", int'(bus.illegal_op), 0);
    step(); nop(); #3;
    chk("illegal in ex", int'(bus.illegal_op), 1);
    step(); #3;
    chk("illegal sticky 1", int'(bus.illegal_op), 1);
    step(); #3;
    chk("illegal sticky 2", int'(bus.illegal_op), 1);

    // Asynchronous reset with STUR in MEM.
    step(); drive(O_STUR, 31, 0, 31);
    step(); nop();
    step(); #3;
    chk("stur mem_write", int'(bus.mem_write_mem), 1);
    rst_n = 1'b0; #1;
    chk("rst mem_write", int'(bus.mem_write_mem), 0);
    chk("rst illegal", int'(bus.illegal_op), 0);
    chk("rst stall_count", int'(bus.stall_count), 0);
    chk("rst pc_write", int'(bus.pc_write), 1);
    @(posedge clk); #2;
    chk("rst held mem_write", int'(bus.mem_write_mem), 0);
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk("rel alu_src", int'(bus.alu_src_ex), 0);
    chk("rel alu_control", int'(bus.alu_control_ex), 0);
    chk("rel mem_read", int'(bus.mem_read_mem), 0);
    chk("rel mem_write", int'(bus.mem_write_mem), 0);
    chk("rel reg_write_wb", int'(bus.reg_write_wb), 0);
    chk("rel mem_to_reg_wb", int'(bus.mem_to_reg_wb), 0);
    chk("rel rd_wb", int'(bus.rd_wb), 0);
    chk("rel forward_a", int'(bus.forward_a), 0);
    chk("rel forward_b", int'(bus.forward_b), 0);
    chk("rel pc_write", int'(bus.pc_write), 1);
    chk("rel ifid_write", int'(bus.ifid_write), 1);
    chk("rel ifid_flush", int'(bus.ifid_flush), 0);
    chk("rel pc_src", int'(bus.pc_src_mem), 0);
    chk("rel illegal", int'(bus.illegal_op), 0);
    chk("rel stall_count", int'(bus.stall_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
